// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-packed-BCD converter (shift-add-3,
// one input bit per enabled clock). Sits downstream of the multiply/scale
// stage and feeds the display/readout logic.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-high; clears all state
//   clk_en  in   global stall; 0 holds every register
//   start   in   conversion request, sampled only in IDLE
//   din     in   WIDTH-bit unsigned value, captured on the accepting edge
//   busy    out  registered; 1 while converting
//   done    out  registered; one-enabled-cycle pulse when bcd updates
//   bcd     out  4*DIGITS packed BCD result, digit 0 (units) in [3:0]
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [WIDTH-1:0]      din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned NB = 4 * DIGITS;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [NB-1:0]     work_q,  work_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic [NB-1:0]     bcd_q,   bcd_d;

  logic [NB-1:0]       adj;
  logic [NB+WIDTH-1:0] shifted;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Per-digit adjust on the current work value; digits are independent.
  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = add3(work_q[4*i +: 4]);
    end
  end

  // {adj, shreg} << 1 : shreg MSB moves into work bit 0.
  assign shifted = {adj[NB-2:0], shreg_q, 1'b0};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = din;
          work_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d  = shifted[NB+WIDTH-1:WIDTH];
        shreg_d = shifted[WIDTH-1:0];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d   = shifted[NB+WIDTH-1:WIDTH];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic [39:0] bcd;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [39:0] q[$];
  logic        done_prev = 1'b0;

  typedef struct {
    logic [31:0] din;
    logic [39:0] exp;
  } vec_t;
  vec_t tbl[8];

  bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .din    (din),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference conversion by repeated division (independent of shift-add-3).
  function automatic logic [39:0] model(input logic [31:0] v);
    logic [39:0] r;
    logic [31:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Scoreboard: each rising done pops one expected result.
  always @(posedge clk) begin
    #1;
    if (!reset && done && !done_prev) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        logic [39:0] e;
        e = q.pop_front();
        if (bcd !== e) begin
          n_fail++;
          $display("FAIL sb_bcd: got %h expected %h (cycle %0d)", bcd, e, cyc);
        end
      end
    end
    done_prev = done;
  end

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic run_conv(input logic [31:0] d, input logic [39:0] e);
    int lat;
    int busy_n;
    bit held;
    logic [39:0] prev;
    prev  = bcd;
    held  = 1'b1;
    start = 1'b1;
    din   = d;
    step();
    q.push_back(e);
    start = 1'b0;
    din   = $urandom;
    lat = 0;
    busy_n = 0;
    while (!done && lat < 200) begin
      if (busy) busy_n++;
      if (bcd !== prev) held = 1'b0;
      step();
      lat++;
    end
    chk("latency", 64'(lat), 64'd32);
    chk("busy_cycles", 64'(busy_n), 64'd32);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("bcd_held", 64'(held), 64'd1);
    step();
    chk("done_clears", 64'(done), 64'd0);
  endtask

  initial begin
    int lat, t1, t2, n_done, hi_n;
    logic [31:0] r;

    tbl[0] = '{32'd0,          40'h0000000000};
    tbl[1] = '{32'd12345,      40'h0000012345};
    tbl[2] = '{32'd400,        40'h0000000400};
    tbl[3] = '{32'hFFFFFFFF,   40'h4294967295};
    tbl[4] = '{32'd99999999,   40'h0099999999};
    tbl[5] = '{32'd1,          40'h0000000001};
    tbl[6] = '{32'd10,         40'h0000000010};
    tbl[7] = '{32'd1000000000, 40'h1000000000};

    reset = 1'b1; clk_en = 1'b1; start = 1'b0; din = '0;
    step(); step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd", 64'(bcd), 64'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_conv(tbl[i].din, tbl[i].exp);

    // Second start at E5 must be ignored.
    start = 1'b1; din = 32'd8642;
    step();
    q.push_back(40'h0000008642);
    start = 1'b0;
    repeat (4) step();
    start = 1'b1; din = 32'd1357;
    step();
    start = 1'b0;
    wait_done(lat);
    chk("hs_latency", 64'(lat + 5), 64'd32);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) n_done++;
    end
    chk("hs_no_second_done", 64'(n_done), 64'd0);
    chk("hs_idle", 64'(busy), 64'd0);

    // Start held high: back-to-back conversions 33 cycles apart.
    start = 1'b1; din = 32'd271828;
    step();
    q.push_back(40'h0000271828);
    din = 32'd314159;
    wait_done(lat);
    t1 = cyc;
    step();
    q.push_back(40'h0000314159);
    din = 32'd5;
    wait_done(lat);
    t2 = cyc;
    start = 1'b0;
    chk("held_spacing", 64'(t2 - t1), 64'd33);
    step();
    chk("held_stops", 64'(busy), 64'd0);

    // Stall for 7 cycles mid-conversion.
    start = 1'b1; din = 32'd2024;
    step();
    q.push_back(40'h0000002024);
    start = 1'b0;
    repeat (4) step();
    clk_en = 1'b0;
    repeat (7) step();
    clk_en = 1'b1;
    wait_done(lat);
    chk("stall_latency", 64'(lat + 11), 64'd39);
    step();

    // Stall during the done cycle.
    start = 1'b1; din = 32'd77;
    step();
    q.push_back(40'h0000000077);
    start = 1'b0;
    wait_done(lat);
    clk_en = 1'b0;
    hi_n = 0;
    repeat (3) begin
      step();
      if (done) hi_n++;
    end
    chk("stall_done_held", 64'(hi_n), 64'd3);
    chk("stall_bcd", 64'(bcd), 64'h0000000077);
    clk_en = 1'b1;
    step();
    chk("stall_done_clears", 64'(done), 64'd0);

    // Reset at cycle 10 of a conversion.
    start = 1'b1; din = 32'd55555;
    step();
    start = 1'b0;
    repeat (9) step();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_bcd", 64'(bcd), 64'd0);
    step();
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) n_done++;
    end
    chk("mid_rst_no_done", 64'(n_done), 64'd0);
    run_conv(32'd777, 40'h0000000777);

    // Reset during a done cycle drops done at once.
    start = 1'b1; din = 32'd31;
    step();
    q.push_back(40'h0000000031);
    start = 1'b0;
    wait_done(lat);
    chk("pre_rst_done", 64'(done), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_done_async", 64'(done), 64'd0);
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      run_conv(r, model(r));
    end

    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
